// File: rtl/jam_cost_server_if.sv
// jam_cost_server_if: load stream and cost lookup bus between the JAM assignment engine and the cost server.
//  master: producer/engine side (drives LD_VALID, LD_DATA, RELOAD, W, J)
//  slave : cost server side (drives LD_READY, TABLE_RDY, Cost, LB_SUM, ACC_CNT)
interface jam_cost_server_if #(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
);
  logic              LD_VALID;
  logic [COST_W-1:0] LD_DATA;
  logic              LD_READY;
  logic              RELOAD;
  logic              TABLE_RDY;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic [SUM_W-1:0]  LB_SUM;
  logic [CNT_W-1:0]  ACC_CNT;
  modport master (
    output LD_VALID, LD_DATA, RELOAD, W, J,
    input  LD_READY, TABLE_RDY, Cost, LB_SUM, ACC_CNT
  );
  modport slave (
    input  LD_VALID, LD_DATA, RELOAD, W, J,
    output LD_READY, TABLE_RDY, Cost, LB_SUM, ACC_CNT
  );
endinterface

// File: rtl/jam_cost_server.sv
// jam_cost_server: 8x8 worker/job cost table with streamed row-major load, zero-latency lookup and row-minimum lower bound.
//  CLK   : clock, rising edge
//  RST_N : asynchronous active-low reset
//  bus   : jam_cost_server_if.slave (load stream, RELOAD, W/J -> Cost, TABLE_RDY, LB_SUM, ACC_CNT)
//  Optional macro ACCESS_CNT_EN: enables the saturating address-change counter on ACC_CNT.
module jam_cost_server #(
  parameter int COST_W = 7,
  parameter int N      = 8,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input logic               CLK,
  input logic               RST_N,
  jam_cost_server_if.slave  bus
);
  typedef enum logic {LOAD, SERVE} state_t;
  state_t            state, state_nx;
  logic [5:0]        idx;
  logic [COST_W-1:0] row_min, beat_min;
  logic [SUM_W-1:0]  lb_sum;
  logic              accept;
  logic [COST_W-1:0] mem [N*N];
  // RELOAD wins over a simultaneous beat, so the beat is never written.
  assign accept   = bus.LD_VALID && state == LOAD && !bus.RELOAD;
  assign beat_min = bus.LD_DATA < row_min ? bus.LD_DATA : row_min;
  assign bus.LB_SUM = lb_sum;
  always_comb begin
    state_nx      = state;
    bus.LD_READY  = state == LOAD;
    bus.TABLE_RDY = state == SERVE;
    bus.Cost      = state == SERVE ? mem[{bus.W, bus.J}] : '0;
    if (bus.RELOAD)
      state_nx = LOAD;
    else if (accept && idx == 6'd63)
      state_nx = SERVE;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= LOAD;
      idx     <= '0;
      row_min <= '1;
      lb_sum  <= '0;
    end else begin
      state <= state_nx;
      if (bus.RELOAD) begin
        idx     <= '0;
        row_min <= '1;
        lb_sum  <= '0;
      end else if (accept) begin
        idx <= idx + 6'd1;
        // Last beat of a row folds its minimum into the bound and re-arms the row tracker.
        if (idx[2:0] == 3'd7) begin
          lb_sum  <= lb_sum + SUM_W'(beat_min);
          row_min <= '1;
        end else begin
          row_min <= beat_min;
        end
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (accept)
      mem[idx] <= bus.LD_DATA;
  end
`ifdef ACCESS_CNT_EN
  logic [5:0]       addr_q;
  logic             addr_vld;
  logic [CNT_W-1:0] acc_cnt;
  assign bus.ACC_CNT = acc_cnt;
  // addr_vld is low on the first SERVE cycle so that cycle always counts as a change.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q   <= '0;
      addr_vld <= 1'b0;
      acc_cnt  <= '0;
    end else if (bus.RELOAD) begin
      addr_vld <= 1'b0;
      acc_cnt  <= '0;
    end else if (state == SERVE) begin
      addr_q   <= {bus.W, bus.J};
      addr_vld <= 1'b1;
      if ((!addr_vld || addr_q != {bus.W, bus.J}) && acc_cnt != '1)
        acc_cnt <= acc_cnt + 1'b1;
    end else begin
      addr_vld <= 1'b0;
    end
  end
`else
  assign bus.ACC_CNT = '0;
`endif
endmodule

// File: tb/tb_jam_cost_server.sv
// tb_jam_cost_server: directed self-checking bench for jam_cost_server.
module tb_jam_cost_server;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  jam_cost_server_if bus ();
  jam_cost_server dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  function automatic int beat(input int kind, input int i);
    return kind == 0 ? i % 128 : kind == 1 ? 127 : 100 - i;
  endfunction
  task automatic load(input int kind, input int from, input int to, input bit gaps);
    for (int i = from; i <= to; i++) begin
      if (gaps && i != from) begin
        bus.LD_VALID = 1'b0;
        tick();
      end
      bus.LD_VALID = 1'b1;
      bus.LD_DATA  = 7'(beat(kind, i));
      tick();
    end
    bus.LD_VALID = 1'b0;
  endtask
  task automatic cost_at(input string tag, input int w, input int j, input int exp);
    bus.W = 3'(w);
    bus.J = 3'(j);
    #1;
    check(tag, 32'(bus.Cost), 32'(exp));
  endtask
  initial begin
    int sw [12] = '{0, 0, 10, 28, 28, 63, 1, 2, 3, 4, 5, 6};
    int acc_exp;
`ifdef ACCESS_CNT_EN
    acc_exp = 10;
`else
    acc_exp = 0;
`endif
    bus.LD_VALID = 1'b0;
    bus.LD_DATA  = '0;
    bus.RELOAD   = 1'b0;
    bus.W        = '0;
    bus.J        = '0;
    #12;
    check("rst_ld_ready", 32'(bus.LD_READY), 1);
    check("rst_table_rdy", 32'(bus.TABLE_RDY), 0);
    check("rst_lb_sum", 32'(bus.LB_SUM), 0);
    check("rst_acc_cnt", 32'(bus.ACC_CNT), 0);
    check("rst_cost", 32'(bus.Cost), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    load(0, 0, 30, 1'b0);
    check("mid_table_rdy", 32'(bus.TABLE_RDY), 0);
    check("mid_cost00", 32'(bus.Cost), 0);
    load(0, 31, 62, 1'b0);
    check("pre_last_table_rdy", 32'(bus.TABLE_RDY), 0);
    check("pre_last_ld_ready", 32'(bus.LD_READY), 1);
    load(0, 63, 63, 1'b0);
    check("t1_table_rdy", 32'(bus.TABLE_RDY), 1);
    check("t1_ld_ready", 32'(bus.LD_READY), 0);
    check("t1_lb_sum", 32'(bus.LB_SUM), 224);
    for (int k = 0; k < 12; k++) begin
      {bus.W, bus.J} = 6'(sw[k]);
      tick();
    end
    check("acc_cnt_sweep", 32'(bus.ACC_CNT), 32'(acc_exp));
    tick();
    tick();
    check("acc_cnt_hold", 32'(bus.ACC_CNT), 32'(acc_exp));
    cost_at("t1_cost35", 3, 5, 29);
    cost_at("t1_cost77", 7, 7, 63);
    cost_at("t1_cost52", 5, 2, 42);
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = '0;
    tick();
    bus.LD_VALID = 1'b0;
    cost_at("serve_ignores_valid", 7, 7, 63);
    check("serve_table_rdy", 32'(bus.TABLE_RDY), 1);
    bus.RELOAD = 1'b1;
    tick();
    bus.RELOAD = 1'b0;
    check("reload_table_rdy", 32'(bus.TABLE_RDY), 0);
    check("reload_ld_ready", 32'(bus.LD_READY), 1);
    check("reload_lb_sum", 32'(bus.LB_SUM), 0);
    check("reload_acc_cnt", 32'(bus.ACC_CNT), 0);
    check("reload_cost", 32'(bus.Cost), 0);
    load(1, 0, 63, 1'b1);
    check("t2_table_rdy", 32'(bus.TABLE_RDY), 1);
    check("t2_lb_sum", 32'(bus.LB_SUM), 1016);
    cost_at("t2_cost26", 2, 6, 127);
    cost_at("t2_cost70", 7, 0, 127);
    bus.RELOAD = 1'b1;
    tick();
    bus.RELOAD = 1'b0;
    load(0, 0, 19, 1'b0);
    check("t4_partial_lb_sum", 32'(bus.LB_SUM), 8);
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = 7'd5;
    bus.RELOAD   = 1'b1;
    tick();
    bus.RELOAD   = 1'b0;
    bus.LD_VALID = 1'b0;
    check("t4_reload_lb_sum", 32'(bus.LB_SUM), 0);
    check("t4_reload_table_rdy", 32'(bus.TABLE_RDY), 0);
    load(2, 0, 62, 1'b0);
    check("t4_pre_last_table_rdy", 32'(bus.TABLE_RDY), 0);
    load(2, 63, 63, 1'b0);
    check("t4_table_rdy", 32'(bus.TABLE_RDY), 1);
    check("t4_lb_sum", 32'(bus.LB_SUM), 520);
    cost_at("t4_cost00", 0, 0, 100);
    cost_at("t4_cost35", 3, 5, 71);
    cost_at("t4_cost77", 7, 7, 37);
    RST_N = 1'b0;
    #1;
    check("t5_table_rdy", 32'(bus.TABLE_RDY), 0);
    check("t5_ld_ready", 32'(bus.LD_READY), 1);
    check("t5_lb_sum", 32'(bus.LB_SUM), 0);
    check("t5_cost", 32'(bus.Cost), 0);
    check("t5_acc_cnt", 32'(bus.ACC_CNT), 0);
    tick();
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    check("t5_post_table_rdy", 32'(bus.TABLE_RDY), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
